// File: rtl/led_matrix_pkg.sv
// Shared types for the 8x8 red/green LED matrix frame store and scanner.
package led_matrix_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef logic [2:0] idx_t;

    // plane[row][col]; a row slice is directly the column drive pattern
    typedef logic [ROWS-1:0][COLS-1:0] plane_t;

    typedef struct packed {
        plane_t red;
        plane_t green;
    } frame_t;

    typedef enum logic {
        BLANK,
        ON
    } scan_state_t;

    function automatic logic [ROWS-1:0] row_onehot(input idx_t r);
        logic [ROWS-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Game-logic side of the frame scheduler: pixel writes, back-buffer clear, swap handshake.
interface led_frame_scheduler_if;
    import led_matrix_pkg::*;

    logic wr_en;
    idx_t wr_row;
    idx_t wr_col;
    logic wr_red;
    logic wr_green;
    logic clr_req;
    logic clr_busy;
    logic swap_req;
    logic swap_ack;

    modport master (
        output wr_en, wr_row, wr_col, wr_red, wr_green, clr_req, swap_req,
        input  clr_busy, swap_ack
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_red, wr_green, clr_req, swap_req,
        output clr_busy, swap_ack
    );

endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered pixel storage: writes and row clears go to the back buffer,
// the scanner reads one row of the front buffer.
module led_frame_buffer
    import led_matrix_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  idx_t            wr_row,
    input  idx_t            wr_col,
    input  logic            wr_red,
    input  logic            wr_green,
    input  logic            clr_en,
    input  idx_t            clr_row,
    input  logic            swap,
    input  idx_t            rd_row,
    output logic [COLS-1:0] rd_red,
    output logic [COLS-1:0] rd_green
);

    frame_t frame_q [2];
    logic   front_sel;
    logic   back_sel;

    assign back_sel = ~front_sel;

    // Back-buffer updates use the pre-swap select, so a write or clear on the
    // swap edge lands in the buffer that is about to become the front.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q[0] <= '0;
            frame_q[1] <= '0;
            front_sel  <= 1'b0;
        end else begin
            if (clr_en) begin
                frame_q[back_sel].red[clr_row]   <= '0;
                frame_q[back_sel].green[clr_row] <= '0;
            end
            if (wr_en) begin
                frame_q[back_sel].red[wr_row][wr_col]   <= wr_red;
                frame_q[back_sel].green[wr_row][wr_col] <= wr_green;
            end
            if (swap) begin
                front_sel <= back_sel;
            end
        end
    end

    assign rd_red   = frame_q[front_sel].red[rd_row];
    assign rd_green = frame_q[front_sel].green[rd_row];

endmodule

// File: rtl/led_frame_scheduler.sv
// Row-scan sequencer for the LED matrix with frame-boundary buffer swap and
// an 8-cycle back-buffer clear.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  BLANK | ticks 0..BLANK_TICKS-1 of a row period, all drives off
//  ON    | ticks BLANK_TICKS..ROW_TICKS-1, row selected, cols latched
//
// All scan outputs are registered and computed from the next tick/row, so the
// value seen during a cycle belongs to that cycle's tick. The first edge after
// reset release starts the scan at tick 0 of row 0 (frame_start pulses there).
// BLANK_TICKS is assumed to be at least 1.
module led_frame_scheduler
    import led_matrix_pkg::*;
#(
    parameter int ROW_TICKS   = 6250,
    parameter int BLANK_TICKS = 64
)
(
    input  logic                   clk,
    input  logic                   reset_n,
    led_frame_scheduler_if.slave   bus,
    output logic                   frame_start,
    output logic [COLS-1:0]        red_cols,
    output logic [COLS-1:0]        green_cols,
    output logic [ROWS-1:0]        row_sink
);

    localparam int                TICK_W    = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ROW_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ON   = TICK_W'(BLANK_TICKS);
    localparam idx_t              ROW_LAST  = 3'd7;

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_nxt;
    idx_t              row_q;
    idx_t              row_nxt;
    logic              started_q;
    scan_state_t       state_q;
    idx_t              clr_row_q;
    logic              clr_busy_q;
    logic              swap_ack_q;
    logic              swap_take;
    logic              wr_take;
    logic [COLS-1:0]   front_red;
    logic [COLS-1:0]   front_green;

    // Next position in the scan; holds at tick 0 / row 0 for the first edge.
    always_comb begin
        tick_nxt = '0;
        row_nxt  = row_q;
        if (!started_q) begin
            row_nxt = '0;
        end else if (tick_q == TICK_LAST) begin
            row_nxt = row_q + 3'd1;
        end else begin
            tick_nxt = tick_q + TICK_W'(1);
        end
    end

    assign swap_take = started_q && (tick_nxt == TICK_LAST) && (row_nxt == ROW_LAST)
                       && bus.swap_req && !clr_busy_q;
    assign wr_take   = bus.wr_en && !clr_busy_q;

    assign bus.clr_busy = clr_busy_q;
    assign bus.swap_ack = swap_ack_q;

    led_frame_buffer u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_take),
        .wr_row   (bus.wr_row),
        .wr_col   (bus.wr_col),
        .wr_red   (bus.wr_red),
        .wr_green (bus.wr_green),
        .clr_en   (clr_busy_q),
        .clr_row  (clr_row_q),
        .swap     (swap_take),
        .rd_row   (row_nxt),
        .rd_red   (front_red),
        .rd_green (front_green)
    );

    // Tick and row position counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q    <= '0;
            row_q     <= '0;
            started_q <= 1'b0;
        end else begin
            tick_q    <= tick_nxt;
            row_q     <= row_nxt;
            started_q <= 1'b1;
        end
    end

    // Clear sequencer: one back row per cycle, rows 0..7, busy for 8 cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_busy_q <= 1'b0;
            clr_row_q  <= '0;
        end else if (clr_busy_q) begin
            clr_row_q <= clr_row_q + 3'd1;
            if (clr_row_q == ROW_LAST) begin
                clr_busy_q <= 1'b0;
            end
        end else if (bus.clr_req) begin
            clr_busy_q <= 1'b1;
            clr_row_q  <= '0;
        end
    end

    // Scan FSM with registered row/column drives, frame and swap pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BLANK;
            row_sink    <= '0;
            red_cols    <= '0;
            green_cols  <= '0;
            frame_start <= 1'b0;
            swap_ack_q  <= 1'b0;
        end else begin
            frame_start <= (tick_nxt == '0) && (row_nxt == '0);
            swap_ack_q  <= swap_take;
            case (state_q)
                BLANK: begin
                    if (tick_nxt == TICK_ON) begin
                        state_q    <= ON;
                        row_sink   <= row_onehot(row_nxt);
                        red_cols   <= front_red;
                        green_cols <= front_green;
                    end
                end
                ON: begin
                    if (tick_nxt == '0) begin
                        state_q    <= BLANK;
                        row_sink   <= '0;
                        red_cols   <= '0;
                        green_cols <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler with a 16-tick row (4 blanking), 128-cycle frame.
module tb_led_frame_scheduler;
    import led_matrix_pkg::*;

    localparam int RT = 16;
    localparam int BT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       frame_start;
    logic [7:0] red_cols;
    logic [7:0] green_cols;
    logic [7:0] row_sink;

    always #5 clk = ~clk;

    led_frame_scheduler_if bus_if ();

    led_frame_scheduler #(.ROW_TICKS(RT), .BLANK_TICKS(BT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus_if),
        .frame_start (frame_start),
        .red_cols    (red_cols),
        .green_cols  (green_cols),
        .row_sink    (row_sink)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: cycle index since scan start, two 8x8 planes per colour,
    // which buffer is displayed, clear cycles remaining, latched row data.
    int         cyc = -1;
    logic [7:0] m_red [2][8];
    logic [7:0] m_grn [2][8];
    int         m_front;
    int         clr_left;
    logic [7:0] disp_red, disp_grn;
    logic       e_fs, e_ack, e_busy;
    logic [7:0] e_red, e_grn, e_sink;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 8; i++) begin
                m_red[b][i] = '0;
                m_grn[b][i] = '0;
            end
        cyc = -1; m_front = 0; clr_left = 0;
        disp_red = '0; disp_grn = '0;
        e_fs = 1'b0; e_ack = 1'b0; e_busy = 1'b0;
        e_red = '0; e_grn = '0; e_sink = '0;
    endtask

    task automatic model_step();
        int t, r, back;
        bit busy_before;
        cyc++;
        t = cyc % RT;
        r = (cyc / RT) % 8;
        busy_before = (clr_left > 0);
        back = 1 - m_front;
        if (busy_before) begin
            m_red[back][8 - clr_left] = '0;
            m_grn[back][8 - clr_left] = '0;
            clr_left--;
        end else if (bus_if.wr_en) begin
            m_red[back][bus_if.wr_row][bus_if.wr_col] = bus_if.wr_red;
            m_grn[back][bus_if.wr_row][bus_if.wr_col] = bus_if.wr_green;
        end
        e_ack = (t == RT - 1) && (r == 7) && bus_if.swap_req && !busy_before;
        if (e_ack) m_front = back;
        if (bus_if.clr_req && !busy_before) clr_left = 8;
        e_busy = (clr_left > 0);
        if (t == BT) begin
            disp_red = m_red[m_front][r];
            disp_grn = m_grn[m_front][r];
        end
        e_fs = (t == 0) && (r == 0);
        if (t >= BT) begin
            e_sink = 8'h01 << r;
            e_red  = disp_red;
            e_grn  = disp_grn;
        end else begin
            e_sink = '0; e_red = '0; e_grn = '0;
        end
    endtask

    initial forever begin
        @(negedge reset_n);
        model_reset();
    end

    initial forever begin
        @(posedge clk);
        if (reset_n) model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("frame_start", frame_start, e_fs);
            chk("swap_ack",    bus_if.swap_ack, e_ack);
            chk("clr_busy",    bus_if.clr_busy, e_busy);
            chk("red_cols",    red_cols, e_red);
            chk("green_cols",  green_cols, e_grn);
            chk("row_sink",    row_sink, e_sink);
        end
    end

    task automatic goto(input int n);
        int guard = 0;
        while (cyc != n && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            total++; bad++;
            $display("FAIL goto got=%0d want=%0d", cyc, n);
        end
    endtask

    // Pixel is sampled on the edge that opens cycle 'at'; returns in cycle 'at'.
    task automatic put_px(input int at, input int r, input int c, input logic rd, input logic gn);
        goto(at - 1);
        bus_if.wr_row   = idx_t'(r);
        bus_if.wr_col   = idx_t'(c);
        bus_if.wr_red   = rd;
        bus_if.wr_green = gn;
        bus_if.wr_en    = 1'b1;
        @(negedge clk);
        bus_if.wr_en    = 1'b0;
    endtask

    initial begin
        bus_if.wr_en = 1'b0; bus_if.wr_row = '0; bus_if.wr_col = '0;
        bus_if.wr_red = 1'b0; bus_if.wr_green = 1'b0;
        bus_if.clr_req = 1'b0; bus_if.swap_req = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_row_sink", row_sink, 8'h00);
        chk("rst_red", red_cols, 8'h00);
        chk("rst_fs", frame_start, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // scan timing after release
        goto(0);  chk("c0_fs", frame_start, 8'h01); chk("c0_sink", row_sink, 8'h00);
        goto(3);  chk("c3_sink", row_sink, 8'h00);
        goto(4);  chk("c4_sink", row_sink, 8'h01); chk("c4_red", red_cols, 8'h00);
        goto(15); chk("c15_sink", row_sink, 8'h01);
        goto(16); chk("c16_sink", row_sink, 8'h00);
        goto(20); chk("c20_sink", row_sink, 8'h02);

        // write (2,5) red and swap at end of frame 0
        put_px(30, 2, 5, 1'b1, 1'b0);
        bus_if.swap_req = 1'b1;
        goto(126); chk("c126_ack", bus_if.swap_ack, 8'h00);
        goto(127); chk("c127_ack", bus_if.swap_ack, 8'h01);
        bus_if.swap_req = 1'b0;
        goto(166); chk("r2_red", red_cols, 8'h20); chk("r2_grn", green_cols, 8'h00);
        chk("r2_sink", row_sink, 8'h04);

        // back-buffer write without swap stays hidden for 3 frames
        put_px(200, 0, 0, 1'b0, 1'b1);
        goto(262); chk("f2_r0_grn", green_cols, 8'h00); chk("f2_r0_sink", row_sink, 8'h01);
        goto(518); chk("f4_r0_grn", green_cols, 8'h00);
        goto(599); bus_if.swap_req = 1'b1;
        goto(639); chk("f4_ack", bus_if.swap_ack, 8'h01);
        bus_if.swap_req = 1'b0;
        goto(646); chk("f5_r0_grn", green_cols, 8'h01); chk("f5_r0_red", red_cols, 8'h00);

        // clear overlapping the frame end defers the swap one frame
        goto(880); bus_if.swap_req = 1'b1;
        goto(891); bus_if.clr_req = 1'b1;
        @(negedge clk); bus_if.clr_req = 1'b0;
        chk("c892_busy", bus_if.clr_busy, 8'h01);
        goto(895);  chk("c895_ack", bus_if.swap_ack, 8'h00); chk("c895_busy", bus_if.clr_busy, 8'h01);
        goto(899);  chk("c899_busy", bus_if.clr_busy, 8'h01);
        goto(900);  chk("c900_busy", bus_if.clr_busy, 8'h00);
        goto(1023); chk("c1023_ack", bus_if.swap_ack, 8'h01);
        bus_if.swap_req = 1'b0;
        goto(1062); chk("cleared_r2_red", red_cols, 8'h00);

        // write on the swap edge shows in the next frame
        goto(1140); bus_if.swap_req = 1'b1;
        put_px(1151, 4, 3, 1'b1, 1'b1);
        chk("c1151_ack", bus_if.swap_ack, 8'h01);
        bus_if.swap_req = 1'b0;
        goto(1158); chk("f9_r0_grn", green_cols, 8'h01);
        goto(1159); bus_if.clr_req = 1'b1;
        @(negedge clk); bus_if.clr_req = 1'b0;
        put_px(1165, 1, 6, 1'b1, 1'b0);
        goto(1222); chk("f9_r4_red", red_cols, 8'h08); chk("f9_r4_grn", green_cols, 8'h08);
        chk("f9_r4_sink", row_sink, 8'h10);
        goto(1260); bus_if.swap_req = 1'b1;
        goto(1279); chk("c1279_ack", bus_if.swap_ack, 8'h01);
        bus_if.swap_req = 1'b0;

        // write during clear was dropped; cancelled request gives no swap
        goto(1299); bus_if.swap_req = 1'b1;
        goto(1302); chk("busy_wr_red", red_cols, 8'h00); chk("f10_r1_sink", row_sink, 8'h02);
        goto(1350); bus_if.swap_req = 1'b0;
        goto(1407); chk("cancel_ack", bus_if.swap_ack, 8'h00);
        goto(1478); chk("cancel_r4_red", red_cols, 8'h00); chk("f11_r4_sink", row_sink, 8'h10);

        // put something on row 5, then reset mid-row with clear and swap pending
        put_px(1481, 5, 1, 1'b1, 1'b0);
        goto(1500); bus_if.swap_req = 1'b1;
        goto(1535); chk("c1535_ack", bus_if.swap_ack, 8'h01);
        goto(1619); bus_if.clr_req = 1'b1;
        @(negedge clk); bus_if.clr_req = 1'b0;
        goto(1625); chk("r5_red", red_cols, 8'h02); chk("r5_sink", row_sink, 8'h20);
        chk("r5_busy", bus_if.clr_busy, 8'h01);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_sink", row_sink, 8'h00);
        chk("mid_rst_red", red_cols, 8'h00);
        chk("mid_rst_busy", bus_if.clr_busy, 8'h00);
        bus_if.swap_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        goto(0);   chk("rel_fs", frame_start, 8'h01); chk("rel_busy", bus_if.clr_busy, 8'h00);
        goto(84);  chk("rel_r5_red", red_cols, 8'h00); chk("rel_r5_sink", row_sink, 8'h20);
        goto(130);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
